// File: rtl/apb_master_nslave.sv
// APB master driving NUM_SLAVES slaves selected by the top address bits.
// Three-state IDLE/SETUP/ACCESS sequencer with a bounded wait counter and a done/err pulse.
module apb_master_nslave #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int NUM_SLAVES  = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                         pclk,
  input  logic                         preset,
  input  logic                         transfer,
  input  logic                         READ_WRITE,
  input  logic [ADDR_W-1:0]            apb_write_paddr,
  input  logic [DATA_W-1:0]            apb_write_data,
  input  logic [ADDR_W-1:0]            apb_read_paddr,
  output logic [DATA_W-1:0]            apb_read_data_out,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [NUM_SLAVES-1:0]        psel,
  output logic                         penable,
  output logic                         pwrite,
  output logic [ADDR_W-1:0]            paddr,
  output logic [DATA_W-1:0]            pwdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]        pready,
  input  logic [NUM_SLAVES-1:0]        pslverr,
  output logic [1:0]                   dbg_state
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SEL_W:0]      NUM_SL_L = (SEL_W+1)'(NUM_SLAVES);
  localparam logic [NUM_SLAVES-1:0] SEL_ONE = NUM_SLAVES'(1);
  localparam logic [CNT_W-1:0]    TMO_L    = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  // Host handshake: transfer is sampled only while busy=0; busy stays high from
  // the accepting edge to the completing edge, and done/err is a one-cycle
  // response presented in the IDLE cycle that follows.
  state_t                  r_state;
  logic [SEL_W-1:0]        r_idx;
  logic [NUM_SLAVES-1:0]   r_psel;
  logic                    r_penable;
  logic                    r_pwrite;
  logic [ADDR_W-1:0]       r_paddr;
  logic [DATA_W-1:0]       r_pwdata;
  logic [DATA_W-1:0]       r_rdata;
  logic                    r_done;
  logic                    r_err;
  logic [CNT_W-1:0]        r_wait;

  logic [ADDR_W-1:0]       w_addr;
  logic [SEL_W-1:0]        w_idx;
  logic                    w_idx_bad;
  logic                    w_ready;
  logic                    w_slverr;
  logic [DATA_W-1:0]       w_rdata;
  logic [CNT_W-1:0]        w_wait_nxt;

  assign w_addr = READ_WRITE ? apb_write_paddr : apb_read_paddr;

  generate
    if (NUM_SLAVES == 1) begin : g_one
      assign w_idx = '0;
    end else begin : g_many
      assign w_idx = w_addr[ADDR_W-1 -: SEL_W];
    end
  endgenerate

  assign w_idx_bad  = ({1'b0, w_idx} >= NUM_SL_L);
  assign w_ready    = pready[r_idx];
  assign w_slverr   = pslverr[r_idx];
  assign w_rdata    = prdata[r_idx*DATA_W +: DATA_W];
  assign w_wait_nxt = r_wait + CNT_W'(1);

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_rdata   <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_wait    <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (transfer) begin
            if (w_idx_bad) begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end else begin
              r_state  <= S_SETUP;
              r_idx    <= w_idx;
              r_psel   <= SEL_ONE << w_idx;
              r_pwrite <= READ_WRITE;
              r_paddr  <= w_addr;
              r_pwdata <= apb_write_data;
            end
          end
        end
        S_SETUP: begin
          r_state   <= S_ACCESS;
          r_penable <= 1'b1;
          r_wait    <= '0;
        end
        S_ACCESS: begin
          if (w_ready) begin
            r_state   <= S_IDLE;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_done    <= 1'b1;
            r_err     <= w_slverr;
            if (!r_pwrite && !w_slverr) r_rdata <= w_rdata;
          end else begin
            r_wait <= w_wait_nxt;
            // Abort on the cycle whose stall would bring the count to the limit.
            if (w_wait_nxt == TMO_L) begin
              r_state   <= S_IDLE;
              r_psel    <= '0;
              r_penable <= 1'b0;
              r_done    <= 1'b1;
              r_err     <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign apb_read_data_out = r_rdata;
  assign busy              = (r_state != S_IDLE);
  assign done              = r_done;
  assign err               = r_err;
  assign psel              = r_psel;
  assign penable           = r_penable;
  assign pwrite            = r_pwrite;
  assign paddr             = r_paddr;
  assign pwdata            = r_pwdata;
  assign dbg_state         = r_state;

endmodule

// File: tb/tb_apb_master_nslave.sv
// Randomized bench for apb_master_nslave: reference model pushes expected completions,
// a monitor pops them on done; a second 3-slave instance covers address decode errors.
module tb_apb_master_nslave;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NS = 2;

  logic pclk = 1'b0;
  logic preset;
  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // main instance (defaults)
  logic           transfer, rw;
  logic [AW-1:0]  wpaddr, rpaddr, paddr;
  logic [DW-1:0]  wdata, rdata_out, pwdata;
  logic           busy, done, err, penable, pwrite;
  logic [NS-1:0]  psel, pready, pslverr;
  logic [NS*DW-1:0] prdata;
  logic [1:0]     dbg_state;

  apb_master_nslave u_dut (
    .pclk(pclk), .preset(preset), .transfer(transfer), .READ_WRITE(rw),
    .apb_write_paddr(wpaddr), .apb_write_data(wdata), .apb_read_paddr(rpaddr),
    .apb_read_data_out(rdata_out), .busy(busy), .done(done), .err(err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .dbg_state(dbg_state)
  );

  // three-slave instance for decode errors
  logic           t3_transfer, t3_rw;
  logic [AW-1:0]  t3_wpaddr, t3_rpaddr, t3_paddr;
  logic [DW-1:0]  t3_wdata, t3_rdata_out, t3_pwdata;
  logic           t3_busy, t3_done, t3_err, t3_penable, t3_pwrite;
  logic [2:0]     t3_psel;
  logic [2:0]     t3_pready  = 3'b111;
  logic [2:0]     t3_pslverr = 3'b000;
  logic [3*DW-1:0] t3_prdata = 24'h332211;
  logic [1:0]     t3_dbg_state;

  apb_master_nslave #(.NUM_SLAVES(3)) u_dut3 (
    .pclk(pclk), .preset(preset), .transfer(t3_transfer), .READ_WRITE(t3_rw),
    .apb_write_paddr(t3_wpaddr), .apb_write_data(t3_wdata), .apb_read_paddr(t3_rpaddr),
    .apb_read_data_out(t3_rdata_out), .busy(t3_busy), .done(t3_done), .err(t3_err),
    .psel(t3_psel), .penable(t3_penable), .pwrite(t3_pwrite), .paddr(t3_paddr),
    .pwdata(t3_pwdata), .prdata(t3_prdata), .pready(t3_pready), .pslverr(t3_pslverr),
    .dbg_state(t3_dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model state: entry = {done_edge[15:0], err, rdata[7:0]}
  logic [24:0]   exp_q[$];
  logic [DW-1:0] model_rdata = '0;
  int            exp_start = 1, exp_end = 0;
  int            tb_idx = 0, tb_wait = 0;
  logic          tb_serr = 1'b0, tb_write = 1'b0;
  logic [AW-1:0] tb_addr = '0;
  logic [DW-1:0] tb_wdata = '0, tb_rdata = '0;
  bit            bus_chk_en = 1'b0;

  // behavioural slaves: random noise everywhere except the addressed slave's
  // ready/error, which answer after tb_wait stalled access cycles
  int acc_cnt = 0;
  always @(negedge pclk) begin
    pready  = 2'($urandom);
    pslverr = 2'($urandom);
    prdata  = 16'($urandom);
    prdata[tb_idx*DW +: DW] = tb_rdata;
    if (penable) begin
      pready[tb_idx] = (acc_cnt == tb_wait);
      if (acc_cnt == tb_wait) pslverr[tb_idx] = tb_serr;
      acc_cnt++;
    end else begin
      acc_cnt = 0;
    end
  end

  // monitor: pop and compare on every done pulse
  always @(negedge pclk) begin
    logic [24:0] e;
    if (!preset && done) begin
      if (exp_q.size() == 0) begin
        chk("done_unexpected", 32'(done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("done_cycle", 32'(cyc[15:0]), 32'(e[24:9]));
        chk("done_err", 32'(err), 32'(e[8]));
        chk("rdata", 32'(rdata_out), 32'(e[7:0]));
      end
    end
  end

  // bus checker: expected bus state from the model's transaction window
  always @(negedge pclk) begin
    bit in_txn;
    if (bus_chk_en) begin
      in_txn = (cyc >= exp_start) && (cyc < exp_end);
      chk("busy", 32'(busy), 32'(in_txn));
      chk("psel", 32'(psel), in_txn ? (32'd1 << tb_idx) : 32'd0);
      chk("penable", 32'(penable), 32'(in_txn && (cyc > exp_start)));
      if (in_txn) begin
        chk("paddr", 32'(paddr), 32'(tb_addr));
        chk("pwrite", 32'(pwrite), 32'(tb_write));
        chk("pwdata", 32'(pwdata), 32'(tb_wdata));
      end
      if (!done) chk("err_idle", 32'(err), 32'd0);
    end
  end

  task automatic rand_host();
    transfer = 1'($urandom);
    rw       = 1'($urandom);
    wpaddr   = 8'($urandom);
    rpaddr   = 8'($urandom);
    wdata    = 8'($urandom);
  endtask

  // waits for the model's completion cycle (toggling host inputs while busy) and issues
  task automatic issue(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input int wt, input bit serr, input logic [DW-1:0] rd);
    int g = 0;
    int e_edge, d_edge;
    bit e_err;
    do begin
      @(negedge pclk);
      g++;
      if (cyc < exp_end) rand_host();
    end while (cyc < exp_end && g < 300);
    if (g >= 300) chk("idle_wait_timeout", 32'd0, 32'd1);
    rw     = wr;
    wdata  = wd;
    wpaddr = wr ? addr : 8'($urandom);
    rpaddr = wr ? 8'($urandom) : addr;
    transfer = 1'b1;
    e_edge = cyc + 1;
    if (wt >= 16) begin
      d_edge = e_edge + 17;
      e_err  = 1'b1;
    end else begin
      d_edge = e_edge + 2 + wt;
      e_err  = serr;
    end
    if (!wr && !e_err) model_rdata = rd;
    tb_idx = int'(addr[AW-1]); tb_wait = wt; tb_serr = serr; tb_rdata = rd;
    tb_write = wr; tb_addr = addr; tb_wdata = wd;
    exp_start = e_edge; exp_end = d_edge;
    exp_q.push_back({16'(d_edge), e_err, model_rdata});
  endtask

  task automatic settle();
    int g = 0;
    do begin
      @(negedge pclk);
      g++;
      if (cyc < exp_end) rand_host(); else transfer = 1'b0;
    end while ((cyc < exp_end || exp_q.size() != 0) && g < 300);
    transfer = 1'b0;
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_psel"}, 32'(psel), 32'd0);
    chk({tag, "_penable"}, 32'(penable), 32'd0);
    chk({tag, "_pwrite"}, 32'(pwrite), 32'd0);
    chk({tag, "_paddr"}, 32'(paddr), 32'd0);
    chk({tag, "_pwdata"}, 32'(pwdata), 32'd0);
    chk({tag, "_rdata"}, 32'(rdata_out), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    preset = 1'b1;
    transfer = 1'b1; rw = 1'b1; wpaddr = 8'h12; rpaddr = 8'h12; wdata = 8'hA5;
    t3_transfer = 1'b0; t3_rw = 1'b0; t3_wpaddr = '0; t3_rpaddr = '0; t3_wdata = '0;
    repeat (3) @(negedge pclk);
    check_zero("reset");
    transfer = 1'b0;
    preset = 1'b0;
    bus_chk_en = 1'b1;

    // directed: zero-wait write, waited read, slave error, wait boundary, timeouts
    issue(1'b1, 8'h12, 8'hA5, 0, 1'b0, 8'h00);
    issue(1'b0, 8'h85, 8'h00, 3, 1'b0, 8'h3C);
    issue(1'b1, 8'h05, 8'h5A, 1, 1'b1, 8'hEE);
    issue(1'b0, 8'h01, 8'h00, 15, 1'b0, 8'h77);
    issue(1'b1, 8'h90, 8'h11, 16, 1'b0, 8'h00);
    issue(1'b0, 8'h81, 8'h00, 16, 1'b0, 8'h99);
    issue(1'b0, 8'h02, 8'h00, 2, 1'b1, 8'h44);

    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 9) == 0) ? 16 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 5)),
            ($urandom_range(0, 4) == 0), 8'($urandom));
    end
    settle();

    // reset in the middle of ACCESS, with transfer held during reset
    issue(1'b0, 8'h85, 8'h00, 10, 1'b0, 8'hC3);
    base = exp_start;
    @(negedge pclk); transfer = 1'b0;
    @(negedge pclk);
    chk("pre_reset_penable", 32'(penable), 32'd1);
    bus_chk_en = 1'b0;
    preset = 1'b1; transfer = 1'b1;
    void'(exp_q.pop_back());
    model_rdata = '0;
    exp_start = 1; exp_end = 0;
    @(negedge pclk);
    check_zero("mid_reset");
    preset = 1'b0; transfer = 1'b0;
    @(negedge pclk);
    chk("after_reset_busy", 32'(busy), 32'd0);
    chk("reset_cycles", 32'(cyc - base), 32'd3);
    bus_chk_en = 1'b1;
    issue(1'b0, 8'h83, 8'h00, 1, 1'b0, 8'h5E);
    issue(1'b1, 8'h33, 8'hC7, 0, 1'b0, 8'h00);
    settle();

    // decode error and a good transfer on the three-slave instance
    t3_rw = 1'b0; t3_rpaddr = 8'hC0; t3_transfer = 1'b1;
    @(negedge pclk); t3_transfer = 1'b0;
    chk("dec_psel", 32'(t3_psel), 32'd0);
    chk("dec_busy", 32'(t3_busy), 32'd0);
    chk("dec_done", 32'(t3_done), 32'd1);
    chk("dec_err", 32'(t3_err), 32'd1);
    chk("dec_rdata", 32'(t3_rdata_out), 32'd0);
    @(negedge pclk);
    chk("dec_done_pulse", 32'(t3_done), 32'd0);
    t3_rpaddr = 8'h80; t3_transfer = 1'b1;
    @(negedge pclk); t3_transfer = 1'b0;
    chk("s3_setup_psel", 32'(t3_psel), 32'b100);
    chk("s3_setup_penable", 32'(t3_penable), 32'd0);
    @(negedge pclk);
    chk("s3_access_penable", 32'(t3_penable), 32'd1);
    @(negedge pclk);
    chk("s3_done", 32'(t3_done), 32'd1);
    chk("s3_err", 32'(t3_err), 32'd0);
    chk("s3_rdata", 32'(t3_rdata_out), 32'h33);
    chk("s3_psel_off", 32'(t3_psel), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_master_nslave.md
APB_MASTER_NSLAVE -- requirements
Module: apb_master_nslave

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the data width.
REQ-003 The block SHALL have parameter NUM_SLAVES, default 2, range 1..16, meaning the number of APB slaves; SEL_W = max(1, clog2(NUM_SLAVES)).
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 16, meaning the maximum number of ACCESS cycles with pready low.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- pclk  in  1  clock.
- preset  in  1  synchronous active-high reset.
- transfer  in  1  host request, sampled only in IDLE.
- READ_WRITE  in  1  1 = write, 0 = read.
- apb_write_paddr  in  ADDR_W  write address.
- apb_write_data  in  DATA_W  write data.
- apb_read_paddr  in  ADDR_W  read address.
- apb_read_data_out  out  DATA_W  registered read data.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; slave error, decode error or timeout.
- psel  out  NUM_SLAVES  one-hot slave select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  NUM_SLAVES*DATA_W  flattened read data; slave i occupies bits [i*DATA_W +: DATA_W].
- pready  in  NUM_SLAVES  per-slave ready.
- pslverr  in  NUM_SLAVES  per-slave error.

Function
REQ-006 The FSM SHALL have exactly three states, IDLE, SETUP and ACCESS, plus the registered done/err pulse.
REQ-007 In IDLE with transfer=1, the block SHALL latch READ_WRITE, the selected address (write address if READ_WRITE=1, else read address) and apb_write_data.
REQ-008 The latched slave index SHALL be address[ADDR_W-1 -: SEL_W]; with NUM_SLAVES=1 the index SHALL be forced to 0.
REQ-009 If the index is >= NUM_SLAVES, the block SHALL assert no psel, pulse done=1 and err=1 on the next cycle, and stay in IDLE.
REQ-010 For a valid index, the next state SHALL be SETUP: psel[idx]=1, penable=0, and paddr, pwrite, pwdata driven from the latched values.
REQ-011 SETUP SHALL always advance to ACCESS after one cycle, with penable=1 and psel, paddr, pwrite, pwdata held stable.
REQ-012 ACCESS SHALL complete on a rising edge where pready[idx]=1.
REQ-013 On ACCESS completion the block SHALL return to IDLE, drop psel and penable, and pulse done=1 for one cycle with err=pslverr[idx].
REQ-014 For a read completion, apb_read_data_out SHALL capture prdata slice idx at the completing edge and hold it until the next read completion.
REQ-015 For a write completion or any error completion, apb_read_data_out SHALL be unchanged.
REQ-016 A wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with pready[idx]=0.
REQ-017 When the wait counter reaches TIMEOUT_CYC, the block SHALL abort to IDLE with done=1 and err=1.
REQ-018 pready and pslverr of unselected slaves SHALL be ignored.
REQ-019 Minimum latency SHALL be: transfer sampled at edge N, SETUP in cycle N+1, ACCESS in cycle N+2, done in cycle N+3 (3 cycles per transfer).
REQ-020 transfer SHALL be ignored while busy=1; there is no queuing.
REQ-021 At most one psel bit SHALL be high at any time.
REQ-022 penable SHALL be high only while the state is ACCESS.

Reset
REQ-023 While preset=1 at a rising edge, the block SHALL go to IDLE and clear psel, penable, pwrite, paddr, pwdata, apb_read_data_out, busy, done, err and the wait counter, all to 0.
REQ-024 A reset asserted during SETUP or ACCESS SHALL abort the transfer with no done pulse.
REQ-025 transfer sampled during the reset cycle SHALL be ignored.

Verification
REQ-026 Defaults, write with zero wait states: write addr 0x12, data 0xA5, pready[0]=1 -> psel=01 with penable low for 1 cycle, then penable high for 1 cycle, then done=1, err=0.
REQ-027 Read with wait states: read addr 0x85, slave1 prdata 0x3C, pready[1] low for 3 cycles -> ACCESS lasts 4 cycles, apb_read_data_out=0x3C, done=1, err=0.
REQ-028 Slave error: write to slave 0 with pslverr[0]=1 at completion -> done=1, err=1, apb_read_data_out unchanged.
REQ-029 Timeout: pready held 0, TIMEOUT_CYC=16 -> abort after 16 ACCESS cycles with done=1, err=1, psel=0.
REQ-030 Decode error: NUM_SLAVES=3, address 0xC0 (index 3) -> no psel, done=1 and err=1 one cycle later.
REQ-031 Reset mid-ACCESS: preset=1 in cycle N+2 -> all outputs 0 at the next cycle, no done pulse, and a following transfer completes normally.
